// File: rtl/smi_frame_arbiter.sv
// Frame-atomic round-robin arbiter that merges four SMI flit streams onto one
// registered output, switching ports only after a flit with non-zero EOFC.
module smi_frame_arbiter #(
    parameter int unsigned FlitWidth = 16,
    parameter int unsigned EofcMask  = 2 * FlitWidth - 1
) (
    input  logic                       clk,
    input  logic                       rstN,
    input  logic [3:0]                 smiInReady,
    input  logic [31:0]                smiInEofc,
    input  logic [4*FlitWidth*8-1:0]   smiInData,
    output logic [3:0]                 smiInStop,
    output logic                       smiOutReady,
    output logic [7:0]                 smiOutEofc,
    output logic [FlitWidth*8-1:0]     smiOutData,
    output logic [1:0]                 smiOutPort,
    input  logic                       smiOutStop
);

    localparam int unsigned DataW    = FlitWidth * 8;
    localparam logic [7:0]  MaskByte = 8'(EofcMask);

    typedef enum logic {ArbIdle, ArbForward} arb_state_e;

    arb_state_e         state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic               out_ready_q, out_ready_d;
    logic [7:0]         out_eofc_q, out_eofc_d;
    logic [1:0]         out_port_q, out_port_d;
    logic [DataW-1:0]   out_data_q, out_data_d;

    logic [7:0]         in_eofc [4];
    logic [DataW-1:0]   in_data [4];
    logic               out_halt;
    logic               accept;
    logic [7:0]         sel_eofc;
    logic [1:0]         pick;
    logic               pick_valid;
    logic [1:0]         idx;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_eofc[i] = smiInEofc[8*i +: 8];
            in_data[i] = smiInData[DataW*i +: DataW];
        end

        out_halt = out_ready_q & smiOutStop;
        sel_eofc = in_eofc[grant_q] & MaskByte;
        accept   = (state_q == ArbForward) & smiInReady[grant_q] & ~out_halt;

        for (int i = 0; i < 4; i++) begin
            smiInStop[i] = smiInReady[i]
                         & ~((state_q == ArbForward) & (grant_q == 2'(i)) & ~out_halt);
        end

        // Scan downward so the lowest offset from last_grant_q wins.
        pick       = 2'd0;
        pick_valid = 1'b0;
        idx        = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = last_grant_q + 2'(k);
            if (smiInReady[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end

        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ArbIdle: begin
                if (pick_valid) begin
                    state_d      = ArbForward;
                    grant_d      = pick;
                    last_grant_d = pick;
                end
            end
            ArbForward: begin
                if (accept && (sel_eofc != 8'd0)) begin
                    state_d = ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase

        out_ready_d = out_ready_q;
        out_eofc_d  = out_eofc_q;
        out_port_d  = out_port_q;
        out_data_d  = out_data_q;
        if (!out_halt) begin
            out_ready_d = accept;
            out_eofc_d  = sel_eofc;
            out_port_d  = grant_q;
            out_data_d  = in_data[grant_q];
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q      <= ArbIdle;
            grant_q      <= 2'd0;
            last_grant_q <= 2'd3;
            out_ready_q  <= 1'b0;
            out_eofc_q   <= 8'd0;
            out_port_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            out_ready_q  <= out_ready_d;
            out_eofc_q   <= out_eofc_d;
            out_port_q   <= out_port_d;
        end
    end

    // Flit payload is qualified by smiOutReady, so it carries no reset.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign smiOutReady = out_ready_q;
    assign smiOutEofc  = out_eofc_q;
    assign smiOutPort  = out_port_q;
    assign smiOutData  = out_data_q;

endmodule

// File: tb/tb_smi_frame_arbiter.sv
// Directed bench for smi_frame_arbiter: per-port frame sources, output transfer
// log, and hand-derived expectations per cycle.
module tb_smi_frame_arbiter;

    localparam int unsigned FlitWidth = 16;
    localparam int unsigned DataW     = FlitWidth * 8;

    logic               clk;
    logic               rstN;
    logic [3:0]         in_ready;
    logic [31:0]        in_eofc;
    logic [4*DataW-1:0] in_data;
    logic [3:0]         in_stop;
    logic               out_ready;
    logic [7:0]         out_eofc;
    logic [DataW-1:0]   out_data;
    logic [1:0]         out_port;
    logic               out_stop;

    smi_frame_arbiter #(.FlitWidth(FlitWidth)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .smiInReady  (in_ready),
        .smiInEofc   (in_eofc),
        .smiInData   (in_data),
        .smiInStop   (in_stop),
        .smiOutReady (out_ready),
        .smiOutEofc  (out_eofc),
        .smiOutData  (out_data),
        .smiOutPort  (out_port),
        .smiOutStop  (out_stop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source model state per port.
    int         cnt [4];
    int         tot [4];
    int         flen [4];
    int         base [4];
    logic [7:0] last_e [4];
    bit         en [4];
    bit         hold [4];

    // Values sampled mid-cycle by cyc().
    logic [3:0]       stop_s;
    logic             ordy_s;
    logic [DataW-1:0] odata_s;
    logic [7:0]       oeofc_s;
    logic [1:0]       oport_s;

    logic [DataW-1:0] q_data [$];
    logic [1:0]       q_port [$];
    logic [7:0]       q_eofc [$];
    bit               rdy_hist [$];

    task automatic chk(input string tag, input logic [DataW-1:0] obs,
                       input logic [DataW-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            in_ready[p]         = en[p] && !hold[p] && (cnt[p] < tot[p]);
            in_eofc[8*p +: 8]   = ((cnt[p] % flen[p]) == flen[p] - 1) ? last_e[p] : 8'd0;
            in_data[DataW*p +: DataW] = DataW'(base[p] + cnt[p]);
        end
    endtask

    task automatic cyc();
        logic [3:0] acc;
        drive();
        #1;
        acc     = in_ready & ~in_stop;
        stop_s  = in_stop;
        ordy_s  = out_ready;
        odata_s = out_data;
        oeofc_s = out_eofc;
        oport_s = out_port;
        rdy_hist.push_back(out_ready);
        if (out_ready && !out_stop) begin
            q_data.push_back(out_data);
            q_port.push_back(out_port);
            q_eofc.push_back(out_eofc);
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) if (acc[p]) cnt[p]++;
    endtask

    task automatic src(input int p, input int t, input int fl, input int b,
                       input logic [7:0] le);
        en[p] = 1'b1; cnt[p] = 0; tot[p] = t; flen[p] = fl; base[p] = b; last_e[p] = le;
    endtask

    // Asserts reset, checks the outputs clear before any clock edge, then releases.
    task automatic do_reset(input string tag);
        rstN = 1'b0;
        for (int p = 0; p < 4; p++) begin
            en[p] = 0; hold[p] = 0; cnt[p] = 0; tot[p] = 0; flen[p] = 1;
            base[p] = 0; last_e[p] = 8'd0;
        end
        in_ready = '0; in_eofc = '0; in_data = '0; out_stop = 1'b0;
        #1;
        chk({tag, "_rst_ready"}, DataW'(out_ready), 0);
        chk({tag, "_rst_eofc"},  DataW'(out_eofc),  0);
        chk({tag, "_rst_port"},  DataW'(out_port),  0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        q_data.delete(); q_port.delete(); q_eofc.delete(); rdy_hist.delete();
    endtask

    initial begin
        rstN = 1'b0;
        in_ready = '0; in_eofc = '0; in_data = '0; out_stop = 1'b0;

        // Single frame on port 2.
        do_reset("t1");
        src(2, 3, 3, 'hA0, 8'd5);
        cyc(); chk("t1_c0_stop", DataW'(stop_s), 4'b0100); chk("t1_c0_rdy", DataW'(ordy_s), 0);
        cyc(); chk("t1_c1_stop", DataW'(stop_s), 4'b0000); chk("t1_c1_rdy", DataW'(ordy_s), 0);
        cyc(); chk("t1_c2_rdy", DataW'(ordy_s), 1); chk("t1_c2_data", odata_s, 'hA0);
        chk("t1_c2_port", DataW'(oport_s), 2); chk("t1_c2_eofc", DataW'(oeofc_s), 0);
        cyc(); chk("t1_c3_rdy", DataW'(ordy_s), 1); chk("t1_c3_data", odata_s, 'hA1);
        chk("t1_c3_eofc", DataW'(oeofc_s), 0);
        cyc(); chk("t1_c4_rdy", DataW'(ordy_s), 1); chk("t1_c4_data", odata_s, 'hA2);
        chk("t1_c4_eofc", DataW'(oeofc_s), 5);
        cyc(); chk("t1_c5_rdy", DataW'(ordy_s), 0);

        // Contention: every port ready with 2-flit frames.
        do_reset("t2");
        src(0, 4, 2, 'h00, 8'd2);
        src(1, 2, 2, 'h10, 8'd2);
        src(2, 2, 2, 'h20, 8'd2);
        src(3, 2, 2, 'h30, 8'd2);
        for (int k = 0; k < 17; k++) cyc();
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("t2_rdy_k%0d", k), DataW'(rdy_hist[k]),
                DataW'((k >= 2) && (((k - 2) % 3) != 2)));
        end
        chk("t2_count", DataW'(q_data.size()), 10);
        if (q_data.size() == 10) begin
            logic [DataW-1:0] exp_d [10];
            logic [1:0]       exp_p [10];
            exp_d = '{'h00, 'h01, 'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h02, 'h03};
            exp_p = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
            for (int i = 0; i < 10; i++) begin
                chk($sformatf("t2_data%0d", i), q_data[i], exp_d[i]);
                chk($sformatf("t2_port%0d", i), DataW'(q_port[i]), DataW'(exp_p[i]));
            end
        end

        // Output backpressure for four cycles mid-frame.
        do_reset("t3");
        src(1, 4, 4, 'hB0, 8'd4);
        cyc(); cyc(); cyc();
        out_stop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk($sformatf("t3_hold_rdy%0d", k),  DataW'(ordy_s), 1);
            chk($sformatf("t3_hold_data%0d", k), odata_s, 'hB1);
            chk($sformatf("t3_hold_stop%0d", k), DataW'(stop_s), 4'b0010);
        end
        out_stop = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        chk("t3_count", DataW'(q_data.size()), 4);
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            chk($sformatf("t3_data%0d", i), q_data[i], DataW'('hB0 + i));
        end

        // Frame lock: port 1 stalls while port 0 waits.
        do_reset("t4");
        src(1, 4, 4, 'hC0, 8'd4);
        cyc();
        src(0, 1, 1, 'hD0, 8'd1);
        cyc(); chk("t4_c1_stop", DataW'(stop_s), 4'b0001);
        hold[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("t4_lock_stop%0d", k), DataW'(stop_s), 4'b0001);
        end
        hold[1] = 1'b0;
        for (int k = 0; k < 7; k++) cyc();
        chk("t4_count", DataW'(q_data.size()), 5);
        if (q_data.size() == 5) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t4_data%0d", i), q_data[i], DataW'('hC0 + i));
                chk($sformatf("t4_port%0d", i), DataW'(q_port[i]), 1);
            end
            chk("t4_data4", q_data[4], 'hD0);
            chk("t4_port4", DataW'(q_port[4]), 0);
        end

        // EOFC masking: 0xF3 & 0x1F terminates the frame with 0x13.
        do_reset("t5");
        src(0, 2, 1, 'hE0, 8'hF3);
        cyc(); cyc();
        cyc(); chk("t5_rdy", DataW'(ordy_s), 1); chk("t5_eofc", DataW'(oeofc_s), 'h13);
        chk("t5_idle_stop", DataW'(stop_s), 4'b0001);

        // Reset mid-frame on port 3, then ports 0 and 3 compete.
        do_reset("t6a");
        src(3, 4, 4, 'hF0, 8'd4);
        cyc(); cyc();
        cyc(); chk("t6_pre_rdy", DataW'(ordy_s), 1); chk("t6_pre_port", DataW'(oport_s), 3);
        do_reset("t6b");
        src(0, 2, 2, 'h50, 8'd2);
        src(3, 2, 2, 'hF0, 8'd2);
        cyc(); chk("t6_c0_stop", DataW'(stop_s), 4'b1001);
        cyc(); chk("t6_c1_stop", DataW'(stop_s), 4'b1000);
        cyc(); chk("t6_c2_rdy", DataW'(ordy_s), 1); chk("t6_c2_port", DataW'(oport_s), 0);
        chk("t6_c2_data", odata_s, 'h50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
